// File: rtl/carrega_instrucao.sv
// Instruction-memory loader: assembles little-endian 32-bit words from a byte
// stream and writes them to consecutive addresses until the all-zero terminator.
module carrega_instrucao #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inicia,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              carregando,
    output logic              pronto,
    output logic              erro,
    output logic [ADDR_W:0]   palavras,
    output logic [1:0]        estado_dbg
);

    // Handshake: a byte moves on a rising clk edge where byte_valid && byte_ready;
    // byte_ready is registered and is only ever high in RECEBE.
    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        RECEBE  = 2'd1,
        ESCREVE = 2'd2,
        FIM     = 2'd3
    } estado_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   PAL_ONE   = 1;

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       word_q, word_d;
    logic              byte_ready_q, byte_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              carregando_q, carregando_d;
    logic              pronto_q, pronto_d;
    logic              erro_q, erro_d;
    logic [ADDR_W:0]   palavras_q, palavras_d;
    logic              xfer;

    always_comb begin
        estado_d     = estado_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        byte_ready_d = byte_ready_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        carregando_d = carregando_q;
        pronto_d     = pronto_q;
        erro_d       = erro_q;
        palavras_d   = palavras_q;
        xfer         = byte_valid && byte_ready_q;

        case (estado_q)
            OCIOSO, FIM: begin
                if (inicia) begin
                    estado_d     = RECEBE;
                    addr_d       = '0;
                    cnt_d        = '0;
                    palavras_d   = '0;
                    erro_d       = 1'b0;
                    pronto_d     = 1'b0;
                    carregando_d = 1'b1;
                    byte_ready_d = 1'b1;
                end
            end
            RECEBE: begin
                if (xfer) begin
                    word_d[{cnt_q, 3'b000} +: 8] = byte_in;
                    cnt_d = cnt_q + 2'd1;
                    // Last byte: present the write on the very next cycle.
                    if (cnt_q == 2'd3) begin
                        estado_d     = ESCREVE;
                        byte_ready_d = 1'b0;
                        wr_en_d      = 1'b1;
                        wr_addr_d    = addr_q;
                        wr_data_d    = word_d;
                    end
                end
            end
            ESCREVE: begin
                palavras_d = palavras_q + PAL_ONE;
                if (word_q == 32'd0 || addr_q == ADDR_LAST) begin
                    estado_d     = FIM;
                    pronto_d     = 1'b1;
                    carregando_d = 1'b0;
                    erro_d       = (word_q != 32'd0);
                end else begin
                    estado_d     = RECEBE;
                    addr_d       = addr_q + ADDR_ONE;
                    byte_ready_d = 1'b1;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q     <= OCIOSO;
            addr_q       <= '0;
            cnt_q        <= '0;
            word_q       <= '0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            carregando_q <= 1'b0;
            pronto_q     <= 1'b0;
            erro_q       <= 1'b0;
            palavras_q   <= '0;
        end else begin
            estado_q     <= estado_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            byte_ready_q <= byte_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            carregando_q <= carregando_d;
            pronto_q     <= pronto_d;
            erro_q       <= erro_d;
            palavras_q   <= palavras_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign carregando = carregando_q;
    assign pronto     = pronto_q;
    assign erro       = erro_q;
    assign palavras   = palavras_q;
    assign estado_dbg = estado_q;

endmodule

// File: tb/tb_carrega_instrucao.sv
// Bench for carrega_instrucao (DEPTH=4): scoreboard of expected writes, a
// monitor on the write port, and directed load scenarios.
module tb_carrega_instrucao;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              inicia = 1'b0;
    logic [7:0]        byte_in = 8'h00;
    logic              byte_valid = 1'b0;
    logic              byte_ready, wr_en, carregando, pronto, erro;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [ADDR_W:0]   palavras;
    logic [1:0]        estado_dbg;

    int errors = 0;
    int checks = 0;
    logic [ADDR_W+31:0] exp_q[$];
    int  mon_cnt = 0;
    logic mon_pend = 1'b0;

    carrega_instrucao #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .inicia(inicia), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .carregando(carregando),
        .pronto(pronto), .erro(erro), .palavras(palavras), .estado_dbg(estado_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: write port against scoreboard, write latency, and exclusivity.
    always @(negedge clk) begin
        if (!rst) begin
            mon_cnt  = 0;
            mon_pend = 1'b0;
        end else begin
            check("wr_en_timing", 64'(wr_en), 64'(mon_pend));
            check("pronto_carregando_excl", 64'(pronto && carregando), 64'd0);
            if (wr_en) begin
                if (exp_q.size() == 0) check("unexpected_write", 64'({wr_addr, wr_data}), 64'hDEAD);
                else check("write_addr_data", 64'({wr_addr, wr_data}), 64'(exp_q.pop_front()));
            end
            mon_pend = byte_valid && byte_ready && (mon_cnt == 3);
            if (byte_valid && byte_ready) mon_cnt = (mon_cnt + 1) % 4;
        end
    end

    task automatic pulse_inicia();
        inicia = 1'b1;
        tick();
        inicia = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int idle);
        int guard;
        byte_valid = 1'b0;
        repeat (idle) tick();
        byte_in    = b;
        byte_valid = 1'b1;
        guard = 0;
        while (!byte_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check("byte_ready_timeout", 64'(byte_ready), 64'd1);
        tick();
        byte_valid = 1'b0;
    endtask

    // Little-endian: byte 0 of the stream lands in bits [7:0].
    task automatic send_word(input logic [31:0] w, input int addr, input int max_idle,
                             input bit mid_inicia);
        exp_q.push_back({ADDR_W'(addr), w});
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], $urandom_range(0, max_idle));
            if (mid_inicia && k == 1) begin
                pulse_inicia();
                check("inicia_ignored_state", 64'(estado_dbg), 64'd1);
            end
        end
    endtask

    task automatic wait_done();
        int g = 0;
        while (!pronto && g < 60) begin
            tick();
            g++;
        end
        check("done_timeout", 64'(pronto), 64'd1);
    endtask

    task automatic basic_load(input int max_idle, input bit mid_inicia);
        send_word(32'h0000A003, 0, max_idle, mid_inicia);
        send_word(32'h0021A223, 1, max_idle, 1'b0);
        send_word(32'h00000000, 2, max_idle, 1'b0);
        wait_done();
        check("basic_palavras", 64'(palavras), 64'd3);
        check("basic_erro", 64'(erro), 64'd0);
        check("basic_carregando", 64'(carregando), 64'd0);
        check("basic_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 64'({byte_ready, wr_en, wr_addr, wr_data, carregando, pronto, erro,
                        palavras, estado_dbg}), 64'd0);
    endtask

    initial begin
        // Reset
        repeat (2) tick();
        check_all_zero("reset_outputs");
        rst = 1'b1;
        tick();
        check_all_zero("after_reset_outputs");

        // Ignored byte_valid in OCIOSO
        byte_in = 8'h55;
        byte_valid = 1'b1;
        repeat (3) tick();
        check("idle_byte_ready", 64'(byte_ready), 64'd0);
        check("idle_state", 64'(estado_dbg), 64'd0);
        byte_valid = 1'b0;

        // Basic load, with inicia pulsed mid-word
        pulse_inicia();
        check("start_byte_ready", 64'(byte_ready), 64'd1);
        check("start_carregando", 64'(carregando), 64'd1);
        basic_load(0, 1'b1);

        // Ignored inputs in FIM
        byte_valid = 1'b1;
        repeat (3) tick();
        check("fim_byte_ready", 64'(byte_ready), 64'd0);
        check("fim_state", 64'(estado_dbg), 64'd3);
        byte_valid = 1'b0;

        // Restart from FIM
        pulse_inicia();
        check("restart_pronto_low", 64'(pronto), 64'd0);
        check("restart_carregando", 64'(carregando), 64'd1);
        check("restart_palavras_clr", 64'(palavras), 64'd0);
        send_word(32'h00A00293, 0, 0, 1'b0);
        send_word(32'h00000000, 1, 0, 1'b0);
        wait_done();
        check("restart_palavras", 64'(palavras), 64'd2);
        check("restart_erro", 64'(erro), 64'd0);

        // Irregular valid
        pulse_inicia();
        basic_load(5, 1'b0);

        // Reset mid-word
        pulse_inicia();
        send_word(32'h0000A003, 0, 0, 1'b0);
        send_byte(8'h23, 0);
        send_byte(8'hA2, 0);
        #2 rst = 1'b0;
        #1 check_all_zero("async_reset_outputs");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("reset_queue_empty", 64'(exp_q.size()), 64'd0);
        pulse_inicia();
        basic_load(2, 1'b0);

        // Overflow: four nonzero words into a 4-deep memory
        pulse_inicia();
        for (int i = 0; i < 4; i++) send_word(32'h00000013, i, 1, 1'b0);
        wait_done();
        check("ovf_erro", 64'(erro), 64'd1);
        check("ovf_palavras", 64'(palavras), 64'd4);
        check("ovf_carregando", 64'(carregando), 64'd0);
        byte_in = 8'h13;
        byte_valid = 1'b1;
        repeat (6) tick();
        check("ovf_fifth_byte_ready", 64'(byte_ready), 64'd0);
        check("ovf_state", 64'(estado_dbg), 64'd3);
        byte_valid = 1'b0;
        repeat (3) tick();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
